// File: rtl/fa_vector_checker.sv
// fa_vector_checker: sweeps a full adder through all 8 {a,b,cin} vectors,
//   samples {carry,sum} after a settle delay and counts mismatches.
// Latency: 2+SETTLE_CYCLES clocks per vector; done pulses in cycle
//   1+8*NUM_PASSES*(2+SETTLE_CYCLES) after start is sampled.
// Backpressure: none; start is only honoured in IDLE and ignored otherwise.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           launch request (IDLE only)
//   a, b, cin       adder operands, registered, = vec[2:0]
//   sum, carry      adder results fed back for checking
//   busy            high from APPLY through CHECK of the final vector
//   done            one-cycle pulse while in DONE
//   pass            last completed run had zero mismatches
//   err_count       saturating mismatch count of last/current run
//   fail_valid, fail_vec  (only with FA_CHECK_FIRST_FAIL_EN) first failing vector
//
// Optional feature macro: FA_CHECK_FIRST_FAIL_EN
module fa_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef FA_CHECK_FIRST_FAIL_EN
  output logic             fail_valid,
  output logic [2:0]       fail_vec,
`endif
  output logic [ERR_W-1:0] err_count
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [2:0]       vec_q;
  logic [PW-1:0]    pidx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [1:0]       exp_w;
  logic             mism_w;
  logic             last_w;
`ifdef FA_CHECK_FIRST_FAIL_EN
  logic             fail_valid_q;
  logic [2:0]       fail_vec_q;
`endif

  // Expected result uses the registered vector, which is what drives the adder.
  assign exp_w  = {1'b0, vec_q[2]} + {1'b0, vec_q[1]} + {1'b0, vec_q[0]};
  assign mism_w = ({carry, sum} != exp_w);
  assign last_w = (vec_q == 3'd7) && (pidx_q == PW'(NUM_PASSES - 1));

  // Saturating increment: the counter parks at all-ones.
  always_comb begin
    err_d = err_q;
    if (mism_w && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= 3'd0;
      pidx_q       <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
`ifdef FA_CHECK_FIRST_FAIL_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q        <= '0;
            pass_q       <= 1'b0;
            vec_q        <= 3'd0;
            pidx_q       <= '0;
            busy_q       <= 1'b1;
`ifdef FA_CHECK_FIRST_FAIL_EN
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
`endif
            state_q      <= S_APPLY;
          end
        end
        S_APPLY: begin
          cnt_q <= CNT_W'(SETTLE_CYCLES);
          if (SETTLE_CYCLES == 0) begin
            state_q <= S_CHECK;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Counter starts at SETTLE_CYCLES, so leaving at 1 gives exactly
          // SETTLE_CYCLES cycles in this state.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
`ifdef FA_CHECK_FIRST_FAIL_EN
          if (mism_w && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec_q;
          end
`endif
          if (last_w) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Uses the post-update count so the final vector is included.
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            vec_q <= vec_q + 3'd1;
            if (vec_q == 3'd7) begin
              pidx_q <= pidx_q + 1'b1;
            end
            state_q <= S_APPLY;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a         = vec_q[2];
  assign b         = vec_q[1];
  assign cin       = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef FA_CHECK_FIRST_FAIL_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`endif

endmodule

// File: tb/tb_fa_vector_checker.sv
// tb_fa_vector_checker: directed test of fa_vector_checker with four
//   instances (good adder, carry stuck-0, inverted sum, zero settle).
// Each run traces busy/done/a/b/cin cycle by cycle against a timing model.
module tb_fa_vector_checker;

  logic clk;
  logic rst;
  logic [3:0] start_v;
  logic [3:0][2:0] abc_w;
  logic [3:0] sum_w;
  logic [3:0] car_w;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] pass_v;
  logic [7:0] err0;
  logic [7:0] err1;
  logic [1:0] err2;
  logic [7:0] err3;
`ifdef FA_CHECK_FIRST_FAIL_EN
  logic [3:0] fv_w;
  logic [3:0][2:0] fvec_w;
`endif

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder models: instances 0 and 3 are correct.
  assign {car_w[0], sum_w[0]} = {1'b0, abc_w[0][2]} + {1'b0, abc_w[0][1]} + {1'b0, abc_w[0][0]};
  assign {car_w[3], sum_w[3]} = {1'b0, abc_w[3][2]} + {1'b0, abc_w[3][1]} + {1'b0, abc_w[3][0]};
  assign sum_w[1] = ^abc_w[1];
  assign car_w[1] = 1'b0;
  assign sum_w[2] = ~(^abc_w[2]);
  assign car_w[2] = (abc_w[2][2] & abc_w[2][1]) | (abc_w[2][2] & abc_w[2][0]) |
                    (abc_w[2][1] & abc_w[2][0]);

  fa_vector_checker u0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .a(abc_w[0][2]), .b(abc_w[0][1]), .cin(abc_w[0][0]),
    .sum(sum_w[0]), .carry(car_w[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
`ifdef FA_CHECK_FIRST_FAIL_EN
    .fail_valid(fv_w[0]), .fail_vec(fvec_w[0]),
`endif
    .err_count(err0)
  );

  fa_vector_checker #(.NUM_PASSES(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .a(abc_w[1][2]), .b(abc_w[1][1]), .cin(abc_w[1][0]),
    .sum(sum_w[1]), .carry(car_w[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
`ifdef FA_CHECK_FIRST_FAIL_EN
    .fail_valid(fv_w[1]), .fail_vec(fvec_w[1]),
`endif
    .err_count(err1)
  );

  fa_vector_checker #(.ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]),
    .a(abc_w[2][2]), .b(abc_w[2][1]), .cin(abc_w[2][0]),
    .sum(sum_w[2]), .carry(car_w[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
`ifdef FA_CHECK_FIRST_FAIL_EN
    .fail_valid(fv_w[2]), .fail_vec(fvec_w[2]),
`endif
    .err_count(err2)
  );

  fa_vector_checker #(.SETTLE_CYCLES(0)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]),
    .a(abc_w[3][2]), .b(abc_w[3][1]), .cin(abc_w[3][0]),
    .sum(sum_w[3]), .carry(car_w[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
`ifdef FA_CHECK_FIRST_FAIL_EN
    .fail_valid(fv_w[3]), .fail_vec(fvec_w[3]),
`endif
    .err_count(err3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_err(input int i);
    case (i)
      0: return int'(err0);
      1: return int'(err1);
      2: return int'(err2);
      default: return int'(err3);
    endcase
  endfunction

  // Launches instance i (start sampled at edge 0) and walks T+6 cycles.
  // L = cycles per vector, P = passes; optional start re-pulses at cycles
  // 5 and 20, optional reset raised in cycle rst_at.
  task automatic run(input string tag, input int i, input int L, input int P,
                     input bit repulse, input int rst_at,
                     output int done_cyc, output int ndone);
    int t;
    int bad;
    int eb, ed, ev;
    t = 8 * P * L;
    bad = 0;
    done_cyc = -1;
    ndone = 0;
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= t + 6; k++) begin
      #1;
      start_v[i] = repulse && (k == 5 || k == 20);
      if (k <= t) begin
        eb = 1; ed = 0; ev = ((k - 1) / L) % 8;
      end else if (k == t + 1) begin
        eb = 0; ed = 1; ev = 7;
      end else begin
        eb = 0; ed = 0; ev = 7;
      end
      if (rst_at > 0 && k > rst_at) begin
        eb = 0; ed = 0; ev = 0;
      end
      if (rst_at > 0 && k == rst_at + 1) begin
        check({tag, "_rst_err"}, get_err(i), 0);
        check({tag, "_rst_abc"}, int'(abc_w[i]), 0);
        check({tag, "_rst_busy"}, int'(busy_v[i]), 0);
        rst = 1'b0;
      end
      if (rst_at > 0 && k == rst_at) rst = 1'b1;
      if (int'(busy_v[i]) != eb || int'(done_v[i]) != ed || int'(abc_w[i]) != ev) begin
        if (bad < 3)
          $display("  trace %s cycle %0d: busy=%0d done=%0d vec=%0d want %0d %0d %0d",
                   tag, k, busy_v[i], done_v[i], abc_w[i], eb, ed, ev);
        bad++;
      end
      if (done_v[i]) begin
        ndone++;
        done_cyc = k;
      end
      @(posedge clk);
    end
    check({tag, "_trace"}, bad, 0);
  endtask

  initial begin
    int dc;
    int nd;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start_v = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_abc", int'(abc_w[0]), 0);
    check("rst_busy", int'(busy_v), 0);
    check("rst_done", int'(done_v), 0);
    check("rst_pass", int'(pass_v), 0);
    check("rst_err", get_err(0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Good adder, defaults.
    run("good", 0, 4, 1, 1'b0, 0, dc, nd);
    check("good_done_cyc", dc, 33);
    check("good_ndone", nd, 1);
    check("good_pass", int'(pass_v[0]), 1);
    check("good_err", get_err(0), 0);

    // Carry stuck at 0, two passes: vectors 3,5,6,7 fail each pass.
    run("cstuck", 1, 4, 2, 1'b0, 0, dc, nd);
    check("cstuck_done_cyc", dc, 65);
    check("cstuck_err", get_err(1), 8);
    check("cstuck_pass", int'(pass_v[1]), 0);
`ifdef FA_CHECK_FIRST_FAIL_EN
    check("cstuck_fail_valid", int'(fv_w[1]), 1);
    check("cstuck_fail_vec", int'(fvec_w[1]), 3);
    check("good_fail_valid", int'(fv_w[0]), 0);
`endif

    // Inverted sum, 2-bit counter saturates at 3.
    run("suminv", 2, 4, 1, 1'b0, 0, dc, nd);
    check("suminv_err", get_err(2), 3);
    check("suminv_pass", int'(pass_v[2]), 0);
    check("suminv_ndone", nd, 1);

    // Zero settle cycles.
    run("nosettle", 3, 2, 1, 1'b0, 0, dc, nd);
    check("nosettle_done_cyc", dc, 17);
    check("nosettle_pass", int'(pass_v[3]), 1);

    // start re-pulsed while busy is ignored.
    run("repulse", 0, 4, 1, 1'b1, 0, dc, nd);
    check("repulse_done_cyc", dc, 33);
    check("repulse_ndone", nd, 1);

    // Mid-run reset: no done, results cleared, then a clean sweep.
    run("midrst", 0, 4, 1, 1'b0, 10, dc, nd);
    check("midrst_ndone", nd, 0);
    check("midrst_pass", int'(pass_v[0]), 0);
    run("after", 0, 4, 1, 1'b0, 0, dc, nd);
    check("after_done_cyc", dc, 33);
    check("after_pass", int'(pass_v[0]), 1);
    check("after_err", get_err(0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
